main_control_fsm: RTL

- Multicycle MIPS main control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux/enable signals, plus the 2-bit ULAOp consumed by the ALU control decoder (ULAOp 00 = add, 10 = R-type funct decode, 01 = subtract for branch compare).
- Sits between the instruction register opcode field and the datapath.

---
 rtl/main_control_fsm.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath mux/enable signals plus the 2-bit
// ULAOp for the ALU control decoder.
// Memory-access states (FETCH, MEMREAD, MEMWRITE) are held for MEM_LAT cycles.
// Optional build macro: BNE_EN adds bne (opcode 0x05) through the BRANCH
// state with the BranchNe output; without it 0x05 is illegal.
module main_control_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [1:0] ULAOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_ADDI_EX  = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Counter value on the final cycle of a memory-access state.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_cycle;
    logic       wait_state;
    logic       op_legal;

    assign last_cycle = (cnt_q == LAST_CNT);
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);

    // Opcodes DECODE knows how to dispatch.
    always_comb begin
        op_legal = (Opcode == OP_RTYPE) || (Opcode == OP_LW) || (Opcode == OP_SW) ||
                   (Opcode == OP_BEQ) || (Opcode == OP_J) || (Opcode == OP_ADDI);
`ifdef BNE_EN
        if (Opcode == OP_BNE) begin
            op_legal = 1'b1;
        end
`endif
    end

    // Next-state selection and wait-counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            S_FETCH:    if (last_cycle) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:  state_d = S_MEMADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EX;
`ifdef BNE_EN
                    OP_BNE:        state_d = S_BRANCH;
`endif
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADDR:  state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (last_cycle) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (last_cycle) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        // Counter restarts on every state entry and only runs while waiting.
        if ((state_d == state_q) && wait_state) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BNE_EN
    logic bne_q;

    // Remember whether the decoded branch is a bne.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bne_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            bne_q <= (Opcode == OP_BNE);
        end
    end
`endif

    // Moore output decode; everything is forced low while reset is high.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ULASrcA     = 1'b0;
        ULASrcB     = 2'b00;
        ULAOp       = 2'b00;
        PCSource    = 2'b00;
        Illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ULASrcB = 2'b01;
                    IRWrite = last_cycle;
                    PCWrite = last_cycle;
                end
                S_DECODE: begin
                    ULASrcB = 2'b11;
                    Illegal = ~op_legal;
                end
                S_MEMADDR: begin
                    ULASrcA = 1'b1;
                    ULASrcB = 2'b10;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RTYPE_EX: begin
                    ULASrcA = 1'b1;
                    ULAOp   = 2'b10;
                end
                S_RTYPE_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ULASrcA     = 1'b1;
                    ULAOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
`ifdef BNE_EN
                    BranchNe    = bne_q;
`endif
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDI_EX: begin
                    ULASrcA = 1'b1;
                    ULASrcB = 2'b10;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign State = state_q;

endmodule
